// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------+
// | cpu_pkg : state, opcode/funct, ALU and extender encodings shared   |
// |           by the multi-cycle control sequencer.                    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_andi  = 6'h0C;
   localparam logic [5:0] c_op_ori   = 6'h0D;
   localparam logic [5:0] c_op_lui   = 6'h0F;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   localparam logic [5:0] c_fn_add = 6'h20;
   localparam logic [5:0] c_fn_sub = 6'h22;
   localparam logic [5:0] c_fn_and = 6'h24;
   localparam logic [5:0] c_fn_or  = 6'h25;
   localparam logic [5:0] c_fn_slt = 6'h2A;

   localparam logic [3:0] c_alu_none = 4'b0000;
   localparam logic [3:0] c_alu_add  = 4'b0001;
   localparam logic [3:0] c_alu_sub  = 4'b0010;
   localparam logic [3:0] c_alu_and  = 4'b0011;
   localparam logic [3:0] c_alu_or   = 4'b0100;
   localparam logic [3:0] c_alu_slt  = 4'b0101;
   localparam logic [3:0] c_alu_lui  = 4'b0110;

   localparam logic [1:0] c_ext_zero = 2'b00;
   localparam logic [1:0] c_ext_sign = 2'b01;
   localparam logic [1:0] c_ext_lui  = 2'b10;

   typedef struct packed {
      logic       legal;
      logic       is_r;
      logic       is_load;
      logic       is_store;
      logic [3:0] aluop;
      logic [1:0] s_ext;
      logic       s_b;
   } dec_t;

endpackage

`default_nettype wire

// File: rtl/mc_decode.sv
// +--------------------------------------------------------------------+
// | mc_decode : combinational op/funct classifier for mc_ctrl.         |
// | Rev 1.0   : initial release                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module mc_decode
   import cpu_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output dec_t       dec
);

   always_comb begin
      dec = '0;
      case (op)
         c_op_rtype: begin
            dec.legal = 1'b1;
            dec.is_r  = 1'b1;
            case (funct)
               c_fn_add: dec.aluop = c_alu_add;
               c_fn_sub: dec.aluop = c_alu_sub;
               c_fn_and: dec.aluop = c_alu_and;
               c_fn_or:  dec.aluop = c_alu_or;
               c_fn_slt: dec.aluop = c_alu_slt;
               default: begin
                  dec.legal = 1'b0;
                  dec.is_r  = 1'b0;
               end
            endcase
         end
         c_op_addi: begin
            dec.legal = 1'b1;
            dec.aluop = c_alu_add;
            dec.s_ext = c_ext_sign;
            dec.s_b   = 1'b1;
         end
         c_op_andi: begin
            dec.legal = 1'b1;
            dec.aluop = c_alu_and;
            dec.s_ext = c_ext_zero;
            dec.s_b   = 1'b1;
         end
         c_op_ori: begin
            dec.legal = 1'b1;
            dec.aluop = c_alu_or;
            dec.s_ext = c_ext_zero;
            dec.s_b   = 1'b1;
         end
         c_op_lui: begin
            dec.legal = 1'b1;
            dec.aluop = c_alu_lui;
            dec.s_ext = c_ext_lui;
            dec.s_b   = 1'b1;
         end
         c_op_lw, c_op_sw: begin
            // address = rs + sign-extended offset
            dec.legal    = 1'b1;
            dec.is_load  = (op == c_op_lw);
            dec.is_store = (op == c_op_sw);
            dec.aluop    = c_alu_add;
            dec.s_ext    = c_ext_sign;
            dec.s_b      = 1'b1;
         end
         default: dec = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl.sv
// +--------------------------------------------------------------------+
// | mc_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer   |
// |           with bounded data-memory wait. MC_CTRL_PERF_EN adds      |
// |           cycle / retired-instruction counters.                    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module mc_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic [3:0]  aluop,
   output logic        s_num_write,
   output logic [1:0]  s_ext,
   output logic        s_b,
   output logic        s_data_write,
   output logic [2:0]  state,
   output logic        illegal,
`ifdef MC_CTRL_PERF_EN
   output logic [31:0] cyc_cnt,
   output logic [31:0] ins_cnt,
`endif
   output logic        bus_err
);

   localparam logic [7:0] c_wait_last = 8'(WAIT_MAX - 1);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       done;
   dec_t       dec;

   mc_decode u_decode (
      .op    (op),
      .funct (funct),
      .dec   (dec)
   );

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      done         = 1'b0;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      reg_write    = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      aluop        = c_alu_none;
      s_num_write  = 1'b0;
      s_ext        = c_ext_zero;
      s_b          = 1'b0;
      s_data_write = 1'b0;
      illegal      = 1'b0;
      bus_err      = 1'b0;
      case (state_q)
         S_FETCH: begin
            pc_write = 1'b1;
            ir_write = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            illegal = ~dec.legal;
            state_d = dec.legal ? S_EXEC : S_FETCH;
         end
         S_EXEC: begin
            aluop   = dec.aluop;
            s_ext   = dec.s_ext;
            s_b     = dec.s_b;
            wait_d  = '0;
            state_d = (dec.is_load || dec.is_store) ? S_MEM : S_WB;
         end
         S_MEM: begin
            aluop     = dec.aluop;
            s_ext     = dec.s_ext;
            s_b       = dec.s_b;
            mem_read  = dec.is_load;
            mem_write = dec.is_store;
            // ready on the limit cycle still completes the access
            if (mem_ready) begin
               done    = dec.is_store;
               state_d = dec.is_load ? S_WB : S_FETCH;
            end else if (wait_q == c_wait_last) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_WB: begin
            reg_write    = 1'b1;
            s_num_write  = dec.is_r;
            s_data_write = dec.is_load;
            done         = 1'b1;
            state_d      = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // state is already FETCH under reset; only the fetch strobes need masking
      if (!reset) begin
         pc_write = 1'b0;
         ir_write = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign state = state_q;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cyc_q, cyc_d, ins_q, ins_d;

   always_comb begin
      cyc_d = cyc_q + 32'd1;
      ins_d = ins_q + {31'd0, done};
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cyc_q <= '0;
         ins_q <= '0;
      end else begin
         cyc_q <= cyc_d;
         ins_q <= ins_d;
      end
   end

   assign cyc_cnt = cyc_q;
   assign ins_cnt = ins_q;
`else
   logic unused_done;
   assign unused_done = done;
`endif

endmodule

`default_nettype wire
